// File: rtl/hazard_stall_ctrl.sv
// Purpose : pipeline hazard sequencer; load-use bubbles, taken-branch flushes, data-memory wait FSM with timeout watchdog.
// Latency : outputs are Mealy (same cycle); load-use = 1 bubble, branch = 1 flushed fetch, memory ack N cycles late = N hold cycles.
// Backpres: memory hold dominates load-use, which dominates branch flush; ERR holds the pipe until reset.
// Ports   : clk/reset_n (async active-low); EX/ID hazard inputs (MemRead_EX, RegWrite_EX, Rd_EX, Rn_ID, Rm_ID, Rd_ID,
//           usesRd_ID, br_taken_ID); memory side (mem_op_MEM, dmem_ack, dmem_req); stage enables (pc_write, ifid_write,
//           ifid_flush, idex_bubble, pipe_hold); status (err_timeout, stall_cnt).
// Config  : define HAZARD_PERF_CNT_EN to build the saturating stall-cycle counter; otherwise stall_cnt is tied to 0.
module hazard_stall_ctrl #(
  parameter int TIMEOUT = 255,
  parameter int CNT_W   = 16
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             MemRead_EX,
  input  logic             RegWrite_EX,
  input  logic [4:0]       Rd_EX,
  input  logic [4:0]       Rn_ID,
  input  logic [4:0]       Rm_ID,
  input  logic [4:0]       Rd_ID,
  input  logic             usesRd_ID,
  input  logic             br_taken_ID,
  input  logic             mem_op_MEM,
  input  logic             dmem_ack,
  output logic             pc_write,
  output logic             ifid_write,
  output logic             ifid_flush,
  output logic             idex_bubble,
  output logic             pipe_hold,
  output logic             dmem_req,
  output logic             err_timeout,
  output logic [CNT_W-1:0] stall_cnt
);

  typedef enum logic [1:0] {
    RUN      = 2'd0,
    MEM_WAIT = 2'd1,
    ERR      = 2'd2
  } state_t;

  localparam logic [7:0] TIMEOUT_CNT = 8'(TIMEOUT);

  state_t     state_q, state_d;
  logic [7:0] wait_cnt_q, wait_cnt_d;
  logic       err_q;

  // Load-use: a load in EX targets a register the ID instruction reads.
  // X31 is the zero register, so it never carries a dependency.
  logic ld_ex;
  logic lu;
  assign ld_ex = MemRead_EX & RegWrite_EX & (Rd_EX != 5'd31);
  assign lu    = ld_ex & ((Rn_ID == Rd_EX) |
                          (Rm_ID == Rd_EX) |
                          (usesRd_ID & (Rd_ID == Rd_EX)));

  // Front-end decision when memory is not holding the pipe.
  logic id_pc_write, id_ifid_write, id_ifid_flush, id_idex_bubble;
  always_comb begin
    id_pc_write    = 1'b1;
    id_ifid_write  = 1'b1;
    id_ifid_flush  = 1'b0;
    id_idex_bubble = 1'b0;
    if (lu) begin
      id_pc_write    = 1'b0;
      id_ifid_write  = 1'b0;
      id_idex_bubble = 1'b1;
    end else if (br_taken_ID) begin
      id_ifid_flush  = 1'b1;
    end
  end

  always_comb begin
    state_d     = state_q;
    wait_cnt_d  = wait_cnt_q;
    pc_write    = 1'b1;
    ifid_write  = 1'b1;
    ifid_flush  = 1'b0;
    idex_bubble = 1'b0;
    pipe_hold   = 1'b0;
    dmem_req    = 1'b0;

    case (state_q)
      RUN: begin
        dmem_req = mem_op_MEM;
        if (mem_op_MEM && !dmem_ack) begin
          // First cycle of a slow access already counts as a hold cycle.
          pipe_hold  = 1'b1;
          pc_write   = 1'b0;
          ifid_write = 1'b0;
          state_d    = MEM_WAIT;
          wait_cnt_d = 8'd1;
        end else begin
          wait_cnt_d  = 8'd0;
          pc_write    = id_pc_write;
          ifid_write  = id_ifid_write;
          ifid_flush  = id_ifid_flush;
          idex_bubble = id_idex_bubble;
        end
      end

      MEM_WAIT: begin
        dmem_req = 1'b1;
        if (dmem_ack) begin
          // Release on the ack cycle; the frozen ID instruction is re-examined now.
          state_d     = RUN;
          wait_cnt_d  = 8'd0;
          pc_write    = id_pc_write;
          ifid_write  = id_ifid_write;
          ifid_flush  = id_ifid_flush;
          idex_bubble = id_idex_bubble;
        end else begin
          pipe_hold  = 1'b1;
          pc_write   = 1'b0;
          ifid_write = 1'b0;
          if (wait_cnt_q == TIMEOUT_CNT) begin
            state_d = ERR;
          end else begin
            wait_cnt_d = wait_cnt_q + 8'd1;
          end
        end
      end

      ERR: begin
        pipe_hold  = 1'b1;
        pc_write   = 1'b0;
        ifid_write = 1'b0;
      end

      default: begin
        state_d    = RUN;
        wait_cnt_d = 8'd0;
      end
    endcase

    // While reset is asserted the outputs show reset values immediately,
    // so an in-flight memory request is withdrawn without waiting for a clock.
    if (!reset_n) begin
      pc_write    = 1'b1;
      ifid_write  = 1'b1;
      ifid_flush  = 1'b0;
      idex_bubble = 1'b0;
      pipe_hold   = 1'b0;
      dmem_req    = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q    <= RUN;
      wait_cnt_q <= 8'd0;
      err_q      <= 1'b0;
    end else begin
      state_q    <= state_d;
      wait_cnt_q <= wait_cnt_d;
      if (state_d == ERR) begin
        err_q <= 1'b1;
      end
    end
  end

  assign err_timeout = err_q;

`ifdef HAZARD_PERF_CNT_EN
  // Counts every cycle the PC is frozen, including ERR; saturates at all-ones.
  logic [CNT_W-1:0] stall_cnt_q;
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      stall_cnt_q <= '0;
    end else if (!pc_write && (stall_cnt_q != {CNT_W{1'b1}})) begin
      stall_cnt_q <= stall_cnt_q + CNT_W'(1);
    end
  end
  assign stall_cnt = stall_cnt_q;
`else
  assign stall_cnt = '0;
`endif

endmodule

// File: tb/tb_hazard_stall_ctrl.sv
module tb_hazard_stall_ctrl;

  localparam int TIMEOUT = 4;
  localparam int CNT_W   = 4;
  localparam int CNT_MAX = (1 << CNT_W) - 1;

  logic             clk = 1'b0;
  logic             reset_n = 1'b0;
  logic             MemRead_EX = 1'b0, RegWrite_EX = 1'b0;
  logic [4:0]       Rd_EX = '0, Rn_ID = '0, Rm_ID = '0, Rd_ID = '0;
  logic             usesRd_ID = 1'b0, br_taken_ID = 1'b0;
  logic             mem_op_MEM = 1'b0, dmem_ack = 1'b0;
  logic             pc_write, ifid_write, ifid_flush, idex_bubble;
  logic             pipe_hold, dmem_req, err_timeout;
  logic [CNT_W-1:0] stall_cnt;

  hazard_stall_ctrl #(.TIMEOUT(TIMEOUT), .CNT_W(CNT_W)) dut (
    .clk(clk), .reset_n(reset_n),
    .MemRead_EX(MemRead_EX), .RegWrite_EX(RegWrite_EX), .Rd_EX(Rd_EX),
    .Rn_ID(Rn_ID), .Rm_ID(Rm_ID), .Rd_ID(Rd_ID), .usesRd_ID(usesRd_ID),
    .br_taken_ID(br_taken_ID), .mem_op_MEM(mem_op_MEM), .dmem_ack(dmem_ack),
    .pc_write(pc_write), .ifid_write(ifid_write), .ifid_flush(ifid_flush),
    .idex_bubble(idex_bubble), .pipe_hold(pipe_hold), .dmem_req(dmem_req),
    .err_timeout(err_timeout), .stall_cnt(stall_cnt)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic             pc;
    logic             ifid;
    logic             flush;
    logic             bubble;
    logic             hold;
    logic             req;
    logic             err;
    logic [CNT_W-1:0] cnt;
  } out_t;

  typedef struct {
    out_t  exp;
    string tag;
  } sb_item_t;

  sb_item_t exp_q[$];
  int  n_checks = 0;
  int  n_fail   = 0;
  bit  stim_done = 1'b0;

  // Reference model: "cycles spent stalled on the current access", a dead flag, and a stall tally.
  int m_waited = 0;
  bit m_dead   = 1'b0;
  int m_cnt    = 0;

  task automatic step(input string tag, input bit rst,
                      input bit mr, input bit rw, input int rde,
                      input int rn, input int rm, input int rdi,
                      input bit ur, input bit br, input bit mo, input bit ack);
    out_t e;
    bit   hazard, mem_stall;
    @(posedge clk);
    #1;
    reset_n     = !rst;
    MemRead_EX  = mr;  RegWrite_EX = rw;
    Rd_EX       = 5'(rde); Rn_ID = 5'(rn); Rm_ID = 5'(rm); Rd_ID = 5'(rdi);
    usesRd_ID   = ur;  br_taken_ID = br;
    mem_op_MEM  = mo;  dmem_ack    = ack;

    e = '0;
    if (rst) begin
      m_waited = 0; m_dead = 1'b0; m_cnt = 0;
      e.pc = 1'b1; e.ifid = 1'b1;
    end else begin
`ifdef HAZARD_PERF_CNT_EN
      e.cnt = CNT_W'(m_cnt);
`endif
      hazard = mr && rw && (rde != 31) &&
               ((rn == rde) || (rm == rde) || (ur && (rdi == rde)));
      if (m_dead) begin
        e.hold = 1'b1; e.err = 1'b1;
      end else begin
        // An access is outstanding if one started earlier or MEM asks now.
        e.req     = (m_waited > 0) || mo;
        mem_stall = e.req && !ack;
        e.pc = 1'b1; e.ifid = 1'b1;
        if (mem_stall) begin
          e.hold = 1'b1; e.pc = 1'b0; e.ifid = 1'b0;
          if (m_waited == TIMEOUT) m_dead = 1'b1;
          else m_waited++;
        end else begin
          m_waited = 0;
          if (hazard) begin
            e.pc = 1'b0; e.ifid = 1'b0; e.bubble = 1'b1;
          end else if (br) begin
            e.flush = 1'b1;
          end
        end
      end
      if (!e.pc && m_cnt < CNT_MAX) m_cnt++;
    end
    exp_q.push_back('{exp: e, tag: tag});
  endtask

  task automatic idle(input string tag);
    step(tag, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
  endtask

  function automatic int pick_reg();
    if ($urandom_range(0, 4) == 0) return 31;
    return int'($urandom_range(0, 3));
  endfunction

  // Stimulus: directed scenarios first, then random traffic.
  initial begin
    step("reset0", 1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    step("reset1", 1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    idle("idle");
    step("loaduse_rm", 0, 1, 1, 3, 0, 3, 0, 0, 0, 0, 0);
    idle("after_lu");
    step("loaduse_rd", 0, 1, 1, 5, 1, 2, 5, 1, 0, 0, 0);
    step("x31_nohaz", 0, 1, 1, 31, 31, 31, 31, 1, 0, 0, 0);
    step("branch", 0, 0, 0, 0, 0, 0, 0, 0, 1, 0, 0);
    step("lu_over_br", 0, 1, 1, 7, 7, 0, 0, 0, 1, 0, 0);
    step("br_under_hold", 0, 0, 0, 0, 0, 0, 0, 0, 1, 1, 0);
    step("br_on_release", 0, 0, 0, 0, 0, 0, 0, 0, 1, 1, 1);
    idle("idle");
    step("memw_req", 0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 0);
    step("memw_w1", 0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 0);
    step("memw_w2", 0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 0);
    step("memw_ack", 0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 1);
    idle("after_memw");
    step("zero_wait", 0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 1);
    idle("after_zw");
    for (int i = 0; i < 8; i++) step("timeout", 0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 0);
    step("err_sticky", 0, 1, 1, 3, 3, 0, 0, 0, 1, 0, 1);
    step("reset_async", 1, 0, 0, 0, 0, 0, 0, 0, 0, 1, 0);
    idle("post_reset");
    for (int i = 0; i < 20; i++) step("saturate", 0, 1, 1, 2, 2, 0, 0, 0, 0, 0, 0);
    idle("sat_idle");

    for (int i = 0; i < 2000; i++) begin
      bit rst;
      rst = ($urandom_range(0, 79) == 0) || (m_dead && $urandom_range(0, 3) == 0);
      step("random", rst,
           $urandom_range(0, 1) == 1, $urandom_range(0, 3) != 0, pick_reg(),
           pick_reg(), pick_reg(), pick_reg(), $urandom_range(0, 1) == 1,
           $urandom_range(0, 3) == 0, $urandom_range(0, 2) == 0,
           $urandom_range(0, 1) == 1);
    end
    stim_done = 1'b1;
  end

  // Monitor: pops one expectation per presented cycle and compares on the falling edge.
  initial begin
    out_t     got;
    sb_item_t it;
    int       budget;
    budget = 0;
    forever begin
      @(negedge clk);
      budget++;
      if (exp_q.size() > 0) begin
        it  = exp_q.pop_front();
        got = '{pc: pc_write, ifid: ifid_write, flush: ifid_flush,
                bubble: idex_bubble, hold: pipe_hold, req: dmem_req,
                err: err_timeout, cnt: stall_cnt};
        n_checks++;
        if (got !== it.exp) begin
          n_fail++;
          $display("FAIL %s @%0t: got pc=%b ifid=%b flush=%b bub=%b hold=%b req=%b err=%b cnt=%0d, need pc=%b ifid=%b flush=%b bub=%b hold=%b req=%b err=%b cnt=%0d",
                   it.tag, $time, got.pc, got.ifid, got.flush, got.bubble, got.hold,
                   got.req, got.err, got.cnt, it.exp.pc, it.exp.ifid, it.exp.flush,
                   it.exp.bubble, it.exp.hold, it.exp.req, it.exp.err, it.exp.cnt);
        end
      end else if (stim_done) begin
        break;
      end
      if (budget > 20000) begin
        n_fail++;
        $display("FAIL watchdog: %0d cycles elapsed, %0d expectations still pending", budget, exp_q.size());
        break;
      end
    end
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/hazard_stall_ctrl.md
# hazard_stall_ctrl

Pipeline hazard sequencer for the 5-stage core. It sits beside the forwarding logic and handles the cases forwarding cannot resolve:
- load-use bubbles;
- taken-branch fetch flushes;
- variable-latency data-memory waits, sequenced by an FSM with a timeout watchdog.

It drives the PC, IF/ID, ID/EX and pipeline-hold enables, and owns the data-memory request handshake.

## Interface
Parameters:
- TIMEOUT, default 255: maximum cycles spent in MEM_WAIT without ack before entering ERR (legal range 1..255).
- CNT_W, default 16: width of the stall performance counter.

Ports:
- clk  input  1  core clock, rising edge.
- reset_n  input  1  reset; one clock, reset is asynchronous and active-low.
- MemRead_EX  input  1  instruction in EX is a load.
- RegWrite_EX  input  1  instruction in EX writes a register.
- Rd_EX  input  5  destination register of the EX instruction.
- Rn_ID, Rm_ID, Rd_ID  input  5 each  source/destination registers of the ID instruction.
- usesRd_ID  input  1  ID instruction reads Rd (STUR, CBZ, MOVK).
- br_taken_ID  input  1  branch resolved taken in ID.
- mem_op_MEM  input  1  load/store in MEM needs data memory.
- dmem_ack  input  1  data memory completes the access this cycle.
- pc_write  output  1  PC register enable.
- ifid_write  output  1  IF/ID register enable.
- ifid_flush  output  1  load NOP into IF/ID.
- idex_bubble  output  1  load NOP controls into ID/EX.
- pipe_hold  output  1  freeze ID/EX, EX/MEM and MEM/WB.
- dmem_req  output  1  data memory request.
- err_timeout  output  1  sticky memory-timeout error.
- stall_cnt  output  CNT_W  stall-cycle count.

## Operation
- Load-use detect (combinational), lu:
  - Requires MemRead_EX & RegWrite_EX & Rd_EX != 31.
  - Matches any of: Rn_ID == Rd_EX; Rm_ID == Rd_EX; usesRd_ID & Rd_ID == Rd_EX.
  - Register 31 never hazards.
- FSM states: RUN, MEM_WAIT, ERR.
- RUN:
  - dmem_req = mem_op_MEM.
  - If mem_op_MEM & !dmem_ack: this cycle is a hold (pipe_hold=1, pc_write=0, ifid_write=0), and next state is MEM_WAIT with wait_cnt=1.
  - Otherwise, if lu: pc_write=0, ifid_write=0, idex_bubble=1.
  - Otherwise, if br_taken_ID: ifid_flush=1 and pc_write=1.
  - Otherwise, all enables are 1 and all flush/bubble outputs are 0.
- MEM_WAIT:
  - Drives dmem_req=1, pipe_hold=1, pc_write=0, ifid_write=0.
  - Drives idex_bubble=0 and ifid_flush=0.
  - On dmem_ack: that same cycle pipe_hold=0, pc_write=1 and ifid_write=1, and lu/br_taken_ID are then evaluated as in RUN; next state is RUN.
  - Else, if wait_cnt == TIMEOUT: next state is ERR.
  - Else wait_cnt increments.
- ERR:
  - Drives pc_write=0, ifid_write=0, pipe_hold=1, dmem_req=0, err_timeout=1.
  - Leaves ERR only via reset.
- Priority: memory hold > load-use > branch flush. A branch or load-use under hold is suppressed; ID is frozen, so it is re-evaluated on release.
- dmem_req stays high from first assertion until the ack cycle; it never drops without an ack except on entering ERR.

## Timing
- Reset values (reset_n low, inputs 0): state RUN, wait_cnt 0, err_timeout 0, stall_cnt 0, pc_write 1, ifid_write 1, all other outputs 0.
- Reset mid-wait aborts the access: dmem_req drops asynchronously.
- Latencies:
  - Load-use costs exactly 1 bubble cycle.
  - Taken branch costs 1 flushed fetch.
  - Zero-wait memory (ack in the request cycle) costs 0 stall cycles.
  - An ack N cycles after the request costs N hold cycles.
- Outputs are Mealy: combinational from state and current inputs. State, wait_cnt, err_timeout and stall_cnt are registered.
- wait_cnt is 8 bits and is cleared whenever the FSM returns to RUN.
- ERR is reached on the cycle after the TIMEOUT-th MEM_WAIT cycle without ack.

## Configuration
- HAZARD_PERF_CNT_EN defined:
  - stall_cnt increments on every clock where pc_write == 0, ERR cycles included.
  - It saturates at all-ones and clears only on reset.
- HAZARD_PERF_CNT_EN undefined: the port remains, stall_cnt is constant 0, and no counter flops are built.

## Test plan
- Load-use: MemRead_EX=1, RegWrite_EX=1, Rd_EX=3, Rm_ID=3 for one cycle -> pc_write=0, ifid_write=0, idex_bubble=1 for exactly that cycle. Repeating with Rd_EX=31 -> no bubble.
- Branch: br_taken_ID=1, no hazards -> ifid_flush=1, pc_write=1 for one cycle. Adding mem_op_MEM=1, dmem_ack=0 in the same cycle -> hold, ifid_flush=0.
- Memory wait: mem_op_MEM=1, ack 3 cycles after request -> dmem_req high 4 cycles, pipe_hold high 3 cycles, release on the ack cycle. With HAZARD_PERF_CNT_EN, stall_cnt=3.
- Zero-wait: mem_op_MEM=1 with dmem_ack=1 in the same cycle -> dmem_req=1, pipe_hold=0, state stays RUN.
- Timeout: TIMEOUT=4, mem_op_MEM=1, no ack -> ERR after 4 MEM_WAIT cycles; err_timeout=1 and dmem_req=0 persist. Asserting reset_n=0 -> all reset values restored asynchronously.
- Saturation: CNT_W=4 with HAZARD_PERF_CNT_EN, 20 stall cycles -> stall_cnt=15. Without the macro -> stall_cnt=0.
